// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional write-to-read
// bypass and a per-register busy scoreboard for long-latency writeback.
module regfile_mp #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [DW-1:0]     wdata1,
  input  logic              bset,
  input  logic [AW-1:0]     baddr,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  output logic              busy_any
);

  localparam int DEPTH = 2 ** AW;
  localparam bit BP    = (BYPASS != 0);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      busy <= '0;
    end else if (ena) begin
      // WP1 beats WP0; a new issue (bset) beats an old writeback clear
      for (int i = 1; i < DEPTH; i++) begin
        if (we1 && waddr1 == AW'(i))
          mem[i] <= wdata1;
        else if (we0 && waddr0 == AW'(i))
          mem[i] <= wdata0;
        if (bset && baddr == AW'(i))
          busy[i] <= 1'b1;
        else if (we1 && waddr1 == AW'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  assign busy_any = ena && !rst && (|busy);

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          live;
    logic          hit0;
    logic          hit1;
    logic          hset;

    assign ra   = raddr[k*AW +: AW];
    assign live = ena && !rst && (ra != '0);
    assign hit0 = BP && we0 && (waddr0 == ra);
    assign hit1 = BP && we1 && (waddr1 == ra);
    assign hset = bset && (baddr == ra);

    assign rdata[k*DW +: DW] = !live ? '0     :
                               hit1  ? wdata1 :
                               hit0  ? wdata0 :
                                       mem[ra];

    // A same-cycle WP1 writeback releases the consumer unless re-issued
    assign rbusy[k] = live && busy[ra] && !(hit1 && !hset);
  end

endmodule
